// File: rtl/vocab_lookup_pkg.sv
// Shared types and helpers for the vocabulary lookup engine.
// The FSM state encoding, the NUL terminator and the ASCII case fold live here.
package vocab_lookup_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [7:0] NUL = 8'h00;

  // Upper-case ASCII letters map onto lower case; everything else passes through.
  function automatic logic [7:0] ascii_fold(input logic [7:0] c);
    ascii_fold = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
  endfunction

endpackage

// File: rtl/vocab_lookup.sv
// Streams a NUL-packed vocabulary from SRAM and reports the ordinal and start address of the entry equal to the query.
// Optional case-insensitive compare when VOCAB_LOOKUP_CASE_FOLD_EN is defined.
module vocab_lookup
  import vocab_lookup_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_LEN    = 8,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [MAX_LEN*DATA_WIDTH-1:0] word_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH-1:0]         end_addr,
  output logic                          mem_re,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [IDX_WIDTH-1:0]          index,
  output logic [ADDR_WIDTH-1:0]         match_addr
);

  localparam int                  PW      = $clog2(MAX_LEN + 1);
  localparam logic [PW-1:0]       POS_MAX = PW'(MAX_LEN);
  localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] CHAR_NUL = DATA_WIDTH'(NUL);

  state_e                  r_state, w_state_next;
  logic [DATA_WIDTH-1:0]   r_word [MAX_LEN];
  logic [ADDR_WIDTH-1:0]   r_end;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_tag;
  logic [ADDR_WIDTH-1:0]   r_entry;
  logic                    r_rv;
  logic [PW-1:0]           r_pos;
  logic                    r_mism;
  logic [IDX_WIDTH-1:0]    r_idx;
  logic                    r_found;
  logic [IDX_WIDTH-1:0]    r_index;
  logic [ADDR_WIDTH-1:0]   r_match_addr;

  logic [DATA_WIDTH-1:0]   w_q_char;
  logic [DATA_WIDTH-1:0]   w_rd_cmp;
  logic [DATA_WIDTH-1:0]   w_q_cmp;
  logic                    w_rd_nul;
  logic                    w_q_nul;
  logic                    w_proc;
  logic                    w_vend;
  logic                    w_hit;
  logic                    w_next_ent;
  logic                    w_miss;
  logic                    w_finish;
  logic [IDX_WIDTH-1:0]    w_idx_inc;

  // Query characters are latched individually so they can be selected by pos.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_word[gi] <= '0;
        end else if (r_state == IDLE && start) begin
          r_word[gi] <= word_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

  // pos == MAX_LEN reads as a virtual terminator past the end of the query.
  always_comb begin
    w_q_char = CHAR_NUL;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (r_pos == PW'(i)) begin
        w_q_char = r_word[i];
      end
    end
  end

`ifdef VOCAB_LOOKUP_CASE_FOLD_EN
  // Folding only ever touches bit 5, so apply it as an XOR on the low byte.
  assign w_rd_cmp = mem_rdata ^ DATA_WIDTH'(ascii_fold(mem_rdata[7:0]) ^ mem_rdata[7:0]);
  assign w_q_cmp  = w_q_char ^ DATA_WIDTH'(ascii_fold(w_q_char[7:0]) ^ w_q_char[7:0]);
`else
  assign w_rd_cmp = mem_rdata;
  assign w_q_cmp  = w_q_char;
`endif

  assign w_rd_nul   = (mem_rdata == CHAR_NUL);
  assign w_q_nul    = (w_q_char == CHAR_NUL);
  assign w_proc     = (r_state == SCAN) && r_rv;
  assign w_vend     = w_proc && w_rd_nul && (r_pos == '0);
  assign w_hit      = w_proc && w_rd_nul && !w_vend && !r_mism &&
                      (w_q_nul || r_pos == POS_MAX);
  assign w_next_ent = w_proc && w_rd_nul && !w_vend && !w_hit;
  // A hit on the end_addr character takes priority over running out of range.
  assign w_miss     = w_vend || (w_proc && (r_tag == r_end) && !w_hit);
  assign w_finish   = w_hit || w_miss;
  assign w_idx_inc  = (r_idx == IDX_MAX) ? r_idx : r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SCAN;
      SCAN:    if (w_finish) w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_re = (r_state == SCAN);
    busy   = (r_state != IDLE);
    done   = (r_state == FIN);
  end

  assign mem_addr   = r_addr;
  assign found      = r_found;
  assign index      = r_index;
  assign match_addr = r_match_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_end        <= '0;
      r_addr       <= '0;
      r_tag        <= '0;
      r_entry      <= '0;
      r_rv         <= 1'b0;
      r_pos        <= '0;
      r_mism       <= 1'b0;
      r_idx        <= '0;
      r_found      <= 1'b0;
      r_index      <= '0;
      r_match_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_end        <= end_addr;
            r_addr       <= base_addr;
            r_entry      <= base_addr;
            r_rv         <= 1'b0;
            r_pos        <= '0;
            r_mism       <= 1'b0;
            r_idx        <= '0;
            r_found      <= 1'b0;
            r_index      <= '0;
            r_match_addr <= '0;
          end
        end
        SCAN: begin
          r_addr <= r_addr + 1'b1;
          r_tag  <= r_addr;
          r_rv   <= 1'b1;
          if (w_proc) begin
            if (w_rd_nul) begin
              if (w_next_ent) begin
                r_idx   <= w_idx_inc;
                r_pos   <= '0;
                r_mism  <= 1'b0;
                r_entry <= r_tag + 1'b1;
              end
            end else begin
              if (r_pos == POS_MAX || w_rd_cmp != w_q_cmp) begin
                r_mism <= 1'b1;
              end
              if (r_pos != POS_MAX) begin
                r_pos <= r_pos + 1'b1;
              end
            end
          end
          // The read issued this cycle is still in flight; drop it.
          if (w_finish) begin
            r_rv         <= 1'b0;
            r_found      <= w_hit;
            r_index      <= w_next_ent ? w_idx_inc : r_idx;
            r_match_addr <= w_hit ? r_entry : '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
